// File: rtl/param_stack_pkg.sv
// Shared types for the parametrised LIFO stack.
// Op encoding is {push, pop}; entry mux selects for stack_entry.
package param_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_ABOVE = 2'b01,
    SEL_BELOW = 2'b10,
    SEL_DIN   = 2'b11
  } entry_sel_t;

  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_entry.sv
// One stack slot: WIDTH-bit register with sync clear
// and a hold / from-above / from-below / din mux.
module stack_entry
  import param_stack_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  entry_sel_t       sel,
  input  logic [WIDTH-1:0] from_above,
  input  logic [WIDTH-1:0] from_below,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge ck) begin
    if (rst) begin
      q <= '0;
    end else begin
      unique case (sel)
        SEL_HOLD:  q <= q;
        SEL_ABOVE: q <= from_above;
        SEL_BELOW: q <= from_below;
        SEL_DIN:   q <= din;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/param_stack.sv
// Parametrised shift-register LIFO; entry 0 is the top.
// Owns occupancy count and sticky ovf/unf flags.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = calc_cnt_w(DEPTH)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stack_op_t        op;
  entry_sel_t       sel [DEPTH];
  logic [WIDTH-1:0] e   [DEPTH];

  assign op    = stack_op_t'({push, pop});
  assign top   = e[0];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      sel[k] = SEL_HOLD;
      unique case (op)
        OP_PUSH: sel[k] = (k == 0) ? SEL_DIN : SEL_ABOVE;
        OP_POP:  sel[k] = empty ? SEL_HOLD : SEL_BELOW;
        OP_REPL: sel[k] = (k == 0) ? SEL_DIN : SEL_HOLD;
        default: sel[k] = SEL_HOLD;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic [WIDTH-1:0] above;
    logic [WIDTH-1:0] below;

    if (k == 0) begin : g_top
      assign above = '0;
    end else begin : g_mid
      assign above = e[k-1];
    end

    // Bottom slot backfills zeros on pop
    if (k == DEPTH - 1) begin : g_bot
      assign below = '0;
    end else begin : g_up
      assign below = e[k+1];
    end

    stack_entry #(
      .WIDTH(WIDTH)
    ) u_ent (
      .ck        (ck),
      .rst       (rst),
      .sel       (sel[k]),
      .from_above(above),
      .from_below(below),
      .din       (din),
      .q         (e[k])
    );
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_PUSH: count <= full  ? CNT_MAX : count + CNT_ONE;
        OP_POP:  count <= empty ? '0      : count - CNT_ONE;
        OP_REPL: count <= empty ? CNT_ONE : count;
        default: count <= count;
      endcase
    end
  end

  // Set beats clear when both happen in one cycle
  always_ff @(posedge ck) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (op == OP_PUSH && full) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (op == OP_POP && empty) begin
        unf <= 1'b1;
      end else if (err_clr) begin
        unf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack, WIDTH=8 DEPTH=4.
module tb_param_stack;

  logic       ck;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic       err_clr;
  logic [7:0] top;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  int n_chk;
  int n_err;

  param_stack #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .ck     (ck),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (din),
    .err_clr(err_clr),
    .top    (top),
    .count  (count),
    .empty  (empty),
    .full   (full),
    .ovf    (ovf),
    .unf    (unf)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive at negedge, take one rising edge, return at next negedge
  task automatic cyc(input logic r, input logic p, input logic q,
                     input logic [7:0] d, input logic c);
    rst     = r;
    push    = p;
    pop     = q;
    din     = d;
    err_clr = c;
    @(posedge ck);
    @(negedge ck);
    rst     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = 8'h00;
    err_clr = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic do_pop();
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic do_repl(input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic do_rst();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_all(input string tag, input logic [7:0] t,
                           input logic [2:0] c, input logic e,
                           input logic f, input logic o,
                           input logic u);
    check({tag, ".top"}, 32'(top), 32'(t));
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".empty"}, 32'(empty), 32'(e));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
    check({tag, ".unf"}, 32'(unf), 32'(u));
  endtask

  logic [7:0] pop_exp2 [4];
  logic [7:0] pop_exp3 [4];

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = 8'h00;
    err_clr = 1'b0;
    pop_exp2 = '{8'h33, 8'h22, 8'h11, 8'h00};
    pop_exp3 = '{8'h44, 8'h33, 8'h22, 8'h00};
    @(negedge ck);

    // 1: reset then idle
    do_rst();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_all("t1_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2: fill and drain
    do_push(8'h11);
    check_all("t2_p1", 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_push(8'h22);
    do_push(8'h33);
    do_push(8'h44);
    check_all("t2_full", 8'h44, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check("t2_pop.top", 32'(top), 32'(pop_exp2[i]));
      check("t2_pop.count", 32'(count), 32'(3 - i));
    end
    check_all("t2_drained", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: overflow discards bottom
    do_push(8'h11);
    do_push(8'h22);
    do_push(8'h33);
    do_push(8'h44);
    do_push(8'h55);
    check_all("t3_ovf", 8'h55, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check("t3_pop.top", 32'(top), 32'(pop_exp3[i]));
    end
    check_all("t3_drained", 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_clr.ovf", 32'(ovf), 32'd0);

    // 4: underflow and sticky clear
    do_pop();
    check_all("t4_unf", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t4_clr.unf", 32'(unf), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    check("t4_setwins.unf", 32'(unf), 32'd1);
    check("t4_setwins.count", 32'(count), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t4_clr2.unf", 32'(unf), 32'd0);

    // 5: replace-top
    do_push(8'hA5);
    do_repl(8'h5A);
    check_all("t5_repl", 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_pop();
    check_all("t5_pop", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_repl(8'h77);
    check_all("t5_repl_empty", 8'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_push(8'h10);
    do_repl(8'h20);
    check("t5_repl2.top", 32'(top), 32'h20);
    check("t5_repl2.count", 32'(count), 32'd2);
    do_pop();
    check("t5_below.top", 32'(top), 32'h77);

    // 6: reset beats push, clears flags
    do_rst();
    do_pop();
    check("t6_pre.unf", 32'(unf), 32'd1);
    do_push(8'h11);
    do_push(8'h22);
    check("t6_pre.count", 32'(count), 32'd2);
    cyc(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
    check_all("t6_rst_push", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_pop();
    check("t6_post.top", 32'(top), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack for the Mica2 datapath; successor to the fixed 8-bit by 4-deep shift stack.
- Built as a shift-register array. Entry 0 is the top and is always visible on `top`.
- Adds over the fixed stack: synchronous reset, occupancy count, empty/full flags, sticky overflow/underflow flags, and an atomic replace-top operation.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries; legal range is 2 or more.
- CNT_W, $clog2(DEPTH+1), width of `count`. Derived; not overridden by the user.

Ports:
- ck  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- push  in  1  push `din` this cycle.
- pop  in  1  pop top entry this cycle.
- din  in  WIDTH  data to push or to replace the top.
- err_clr  in  1  clears the sticky `ovf` and `unf` flags.
- top  out  WIDTH  current entry 0; combinational read of a register.
- count  out  CNT_W  number of valid entries, 0 to DEPTH.
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.
- ovf  out  1  sticky; set when a push is made while full.
- unf  out  1  sticky; set when a pop is made while empty.

Behaviour:
- Reset: `rst` is synchronous and active-high. `rst` high at a rising edge of `ck` forces all entries to 0 and count to 0.
  - Resulting outputs: top = 0, empty = 1, full = 0, ovf = 0, unf = 0.
  - Reset takes priority over every other input.
- Operation decode, from {push, pop}:
  - 00 = NOP
  - 10 = PUSH
  - 01 = POP
  - 11 = REPL
- NOP: state holds.
- PUSH:
  - e[k] <= e[k-1] for k = 1..DEPTH-1; e[0] <= din.
  - count <= count + 1, saturating at DEPTH.
  - If full, the bottom entry e[DEPTH-1] is discarded (lossy, as in the fixed stack) and ovf <= 1.
- POP:
  - e[k] <= e[k+1] for k = 0..DEPTH-2; e[DEPTH-1] <= 0.
  - count <= count - 1.
  - If empty: entries are unchanged, count stays 0 and unf <= 1.
- REPL:
  - e[0] <= din; other entries are unchanged.
  - If not empty, count is unchanged.
  - If empty, count <= 1.
  - REPL never sets ovf or unf.
- Latency: the effect of an operation is visible on top/count/flags in the cycle after the edge. No read latency beyond the register.
- empty and full are decoded combinationally from the count register; they are never independent state.
- ovf and unf are sticky:
  - err_clr clears them at the edge.
  - If err_clr and a new error occur in the same cycle, the set wins (the flag stays 1).
- Invalid entries (index >= count) always read as 0. Pops backfill zeros; reset zeroes everything.
- count never exceeds DEPTH and never wraps below 0.

Decomposition:
- Package param_stack_pkg holds:
  - The 2-bit enum stack_op_t: OP_NOP, OP_PUSH, OP_POP, OP_REPL, encoded {push,pop}.
  - A function computing CNT_W from DEPTH.
- One sub-module, stack_entry: a WIDTH-bit register with a synchronous clear and a 4-way next-value mux.
  - Mux inputs: hold, from-above, from-below, din.
  - param_stack instantiates DEPTH copies via generate and owns the count/flag logic.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset then idle 3 cycles -> top=0x00, count=0, empty=1, full=0, ovf=0, unf=0.
2. Push 0x11, 0x22, 0x33, 0x44 -> top=0x44, count=4, full=1; then pop x4 -> top reads 0x33, 0x22, 0x11, 0x00, empty=1, no flags set.
3. Fill with 0x11..0x44, push 0x55 -> top=0x55, count=4, ovf=1; pop x4 -> 0x44, 0x33, 0x22, then 0x00 (0x11 was lost).
4. Pop while empty -> count=0, top=0x00, unf=1; assert err_clr alone -> unf=0 the next cycle; err_clr together with an empty pop -> unf stays 1.
5. Push 0xA5, REPL 0x5A -> top=0x5A, count=1; REPL 0x77 from empty -> top=0x77, count=1, no flags.
6. Push 0x11, 0x22, then assert rst together with a push of 0x99 -> count=0, top=0x00, all flags 0; the push is ignored.
